// File: rtl/dma_gic_pkg.sv
// Shared constants for the DMA GIC interrupt receiver: line count, register
// offsets and the default per-line counter width.
package dma_gic_pkg;

  localparam int unsigned NUM_IRQ   = 3;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  localparam logic [ADDR_W-1:0] OFF_STATUS = 5'h00;
  localparam logic [ADDR_W-1:0] OFF_ENABLE = 5'h04;
  localparam logic [ADDR_W-1:0] OFF_MODE   = 5'h08;
  localparam logic [ADDR_W-1:0] OFF_COUNT  = 5'h0C;
  localparam logic [ADDR_W-1:0] OFF_RAW    = 5'h10;

  // Word match on a byte address; the two byte-lane bits are ignored.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] off);
    return addr[ADDR_W-1:2] == off[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/dma_pcie_gic_if.sv
// Interrupt lines from the DMA engine, synchronous to the receiver clock.
interface dma_pcie_gic_if;
  import dma_gic_pkg::*;

  logic [NUM_IRQ-1:0] interrupt;

  modport s (input interrupt);
  modport m (output interrupt);
endinterface

// File: rtl/dma_gic_irq_line.sv
// One interrupt line: input staging, rising-edge detect, sticky pending bit
// and a saturating, read-clearable event counter.
module dma_gic_irq_line #(
  parameter int unsigned CNT_W = dma_gic_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_i,
  input  logic             mode_i,
  input  logic             pend_clr_i,
  input  logic             cnt_clr_i,
  output logic             s1_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q;
  logic             prev_q;
  logic             pend_q;
  logic             pend_d;
  logic             rise;
  logic             set;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign rise = s1_q & ~prev_q;
  assign set  = mode_i ? rise : s1_q;

  // Set beats a coincident clear; a rise during a read-clear counts as one.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (pend_clr_i) begin
      pend_d = 1'b0;
    end
    if (set) begin
      pend_d = 1'b1;
    end
    if (cnt_clr_i) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= irq_i;
      prev_q <= s1_q;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s1_o   = s1_q;
  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/dma_gic_irq_rx.sv
// DMA GIC interrupt receiver: per-line capture, register file and the
// masked level interrupt to the processor.
module dma_gic_irq_rx
  import dma_gic_pkg::*;
#(
  parameter int unsigned        CNT_W    = CNT_W_DEF,
  parameter logic [NUM_IRQ-1:0] MODE_RST = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  dma_pcie_gic_if.s         gic,
  input  logic              reg_wr_en,
  input  logic              reg_rd_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rd_vld,
  output logic              irq_o
);

  logic [NUM_IRQ-1:0]       s1;
  logic [NUM_IRQ-1:0]       pend;
  logic [NUM_IRQ-1:0]       pend_clr;
  logic [NUM_IRQ*CNT_W-1:0] cnt_vec;
  logic                     cnt_clr;

  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] enable_d;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] mode_d;
  logic [DATA_W-1:0]  rd_mux;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  rdata_d;
  logic               rd_vld_q;
  logic               rd_vld_d;
  logic               irq_q;
  logic               irq_d;
  logic               unused_bits;

  assign unused_bits = ^{reg_addr[1:0], reg_wdata[DATA_W-1:NUM_IRQ]};

  assign pend_clr = (reg_wr_en && addr_hit(reg_addr, OFF_STATUS)) ?
                    reg_wdata[NUM_IRQ-1:0] : '0;
  assign cnt_clr  = reg_rd_en && addr_hit(reg_addr, OFF_COUNT);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    dma_gic_irq_line #(.CNT_W(CNT_W)) u_line (
      .clk        (clk),
      .rst        (rst),
      .irq_i      (gic.interrupt[i]),
      .mode_i     (mode_q[i]),
      .pend_clr_i (pend_clr[i]),
      .cnt_clr_i  (cnt_clr),
      .s1_o       (s1[i]),
      .pend_o     (pend[i]),
      .cnt_o      (cnt_vec[i*CNT_W +: CNT_W])
    );
  end

  // Reads sample pre-write register contents, so a same-cycle write is invisible.
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    rd_mux   = '0;
    if (reg_wr_en && addr_hit(reg_addr, OFF_ENABLE)) begin
      enable_d = reg_wdata[NUM_IRQ-1:0];
    end
    if (reg_wr_en && addr_hit(reg_addr, OFF_MODE)) begin
      mode_d = reg_wdata[NUM_IRQ-1:0];
    end
    if (addr_hit(reg_addr, OFF_STATUS)) begin
      rd_mux = DATA_W'(pend);
    end else if (addr_hit(reg_addr, OFF_ENABLE)) begin
      rd_mux = DATA_W'(enable_q);
    end else if (addr_hit(reg_addr, OFF_MODE)) begin
      rd_mux = DATA_W'(mode_q);
    end else if (addr_hit(reg_addr, OFF_COUNT)) begin
      rd_mux = DATA_W'(cnt_vec);
    end else if (addr_hit(reg_addr, OFF_RAW)) begin
      rd_mux = DATA_W'(s1);
    end
    rdata_d  = reg_rd_en ? rd_mux : '0;
    rd_vld_d = reg_rd_en;
    irq_d    = |(pend & enable_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      mode_q   <= MODE_RST;
      rdata_q  <= '0;
      rd_vld_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rd_vld_q <= rd_vld_d;
      irq_q    <= irq_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rd_vld = rd_vld_q;
  assign irq_o      = irq_q;

endmodule
